usb_in_ep_pkt_buf: RTL

Endpoint-side packet buffer for a USB IN (device-to-host) endpoint. It implements the in_ep_* interface the serial FIFO endpoint drives, and faces the USB protocol engine.
- Application side: collects bytes put by the application into a single packet buffer of up to MAX_PKT bytes.
- Commit: the packet is committed on full or on in_ep_data_done.
- Protocol side: answers IN tokens with NAK, STALL or DATA0/DATA1, streams the payload to the serializer and retries on handshake timeout.
- Completion: the DATA toggle advances and the buffer is released only on host ACK.

---
 rtl/usb_in_ep_pkt_buf.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/usb_in_ep_pkt_buf.sv
// USB IN endpoint packet buffer: gathers application bytes into one packet, answers IN tokens
// with NAK/STALL/DATAx, streams the payload and releases the buffer only on host ACK.
module usb_in_ep_pkt_buf #(
  parameter int unsigned MAX_PKT = 32,
  parameter int unsigned AW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  output logic          in_ep_data_free,
  input  logic          in_ep_data_put,
  input  logic [7:0]    in_ep_data,
  input  logic          in_ep_data_done,
  input  logic          in_ep_stall,
  output logic          in_ep_acked,
  input  logic          in_tok,
  output logic          resp_valid,
  output logic [1:0]    resp_type,
  output logic          tx_pid_data1,
  output logic [AW:0]   tx_len,
  output logic          tx_data_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_data_ready,
  output logic          tx_last,
  input  logic          hs_ack,
  input  logic          hs_timeout,
  input  logic          toggle_clr
);

  typedef enum logic [1:0] {StFill, StReady, StSend, StWaitHs} state_e;

  localparam logic [1:0]  RespNak   = 2'd0;
  localparam logic [1:0]  RespStall = 2'd1;
  localparam logic [1:0]  RespData  = 2'd2;
  localparam logic [AW:0] MaxCount  = (AW + 1)'(MAX_PKT);
  localparam logic [AW:0] LastCount = (AW + 1)'(MAX_PKT - 1);

  state_e         r_state, w_state_nxt;
  logic [AW:0]    r_count, w_count_nxt;
  logic [AW-1:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic           r_toggle, w_toggle_nxt;
  logic           r_free, w_free_nxt;
  logic           r_acked, w_acked_nxt;
  logic           r_resp_valid, w_resp_valid_nxt;
  logic [1:0]     r_resp_type, w_resp_type_nxt;
  logic           r_pid, w_pid_nxt;
  logic [AW:0]    r_tx_len, w_tx_len_nxt;
  logic [7:0]     r_buf [MAX_PKT];

  logic           w_wr_en;
  logic           w_tx_valid;
  logic           w_tx_last;

  assign w_wr_en    = (r_state == StFill) && r_free && in_ep_data_put;
  // Payload starts the cycle after the response pulse; empty packets never present a byte.
  assign w_tx_valid = (r_state == StSend) && !r_resp_valid && (r_count != '0);
  assign w_tx_last  = w_tx_valid && ({1'b0, r_rd_ptr} == (r_count - (AW + 1)'(1)));

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_toggle_nxt     = r_toggle;
    w_acked_nxt      = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_type_nxt  = r_resp_type;
    w_pid_nxt        = r_pid;
    w_tx_len_nxt     = r_tx_len;

    unique case (r_state)
      StFill: begin
        if (w_wr_en) begin
          w_count_nxt = r_count + (AW + 1)'(1);
        end
        if (in_ep_data_done || (w_wr_en && (r_count == LastCount))) begin
          w_state_nxt = StReady;
        end
      end
      StReady: begin
      end
      StSend: begin
        if (r_count == '0) begin
          w_state_nxt = StWaitHs;
        end else if (w_tx_valid && tx_data_ready) begin
          if (w_tx_last) begin
            w_state_nxt  = StWaitHs;
            w_rd_ptr_nxt = '0;
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
          end
        end
      end
      StWaitHs: begin
        if (hs_ack) begin
          w_toggle_nxt = ~r_toggle;
          w_count_nxt  = '0;
          w_acked_nxt  = 1'b1;
          w_state_nxt  = StFill;
        end else if (hs_timeout) begin
          w_state_nxt = StReady;
        end
      end
    endcase

    if (in_tok && ((r_state == StFill) || (r_state == StReady))) begin
      w_resp_valid_nxt = 1'b1;
      if (in_ep_stall) begin
        w_resp_type_nxt = RespStall;
        w_tx_len_nxt    = '0;
      end else if (r_state == StFill) begin
        w_resp_type_nxt = RespNak;
        w_tx_len_nxt    = '0;
      end else begin
        w_resp_type_nxt = RespData;
        w_tx_len_nxt    = r_count;
        w_pid_nxt       = r_toggle;
        w_rd_ptr_nxt    = '0;
        w_state_nxt     = StSend;
      end
    end

    // Clear wins over a same-cycle ACK flip.
    if (toggle_clr) begin
      w_toggle_nxt = 1'b0;
    end

    w_free_nxt = (w_state_nxt == StFill) && (w_count_nxt < MaxCount);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StFill;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_toggle     <= 1'b0;
      r_free       <= 1'b1;
      r_acked      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_type  <= RespNak;
      r_pid        <= 1'b0;
      r_tx_len     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_toggle     <= w_toggle_nxt;
      r_free       <= w_free_nxt;
      r_acked      <= w_acked_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_type  <= w_resp_type_nxt;
      r_pid        <= w_pid_nxt;
      r_tx_len     <= w_tx_len_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[r_count[AW-1:0]] <= in_ep_data;
    end
  end

  assign in_ep_data_free = r_free;
  assign in_ep_acked     = r_acked;
  assign resp_valid      = r_resp_valid;
  assign resp_type       = r_resp_type;
  assign tx_pid_data1    = r_pid;
  assign tx_len          = r_tx_len;
  assign tx_data_valid   = w_tx_valid;
  assign tx_data         = r_buf[r_rd_ptr];
  assign tx_last         = w_tx_last;

endmodule
